irq_controller: RTL and testbench

Parametrised interrupt controller that replaces the fixed four-line interrupt wiring to the CPU. It aggregates NUM_SRC sources into one prioritised request, either internal (timers, UART RX, frameDrawn) or external (nint pins). Per-source mask, pending and edge/level mode are held in a small CPU-visible register file. It sits between the peripherals/MemoryUnit and the CPU interrupt input, with an ack/EOI handshake.

---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_src_sync.sv | 54 +++++
 rtl/irq_controller.sv | 148 ++++++++++++++
 tb/tb_irq_controller.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared register offsets, FSM encoding and flag positions for
//               the interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    localparam logic [1:0] REG_MASK    = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_MODE    = 2'd2;
    localparam logic [1:0] REG_ACTIVE  = 2'd3;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REQ    = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    localparam int ACTIVE_FLAG_BIT = 31;

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_src_sync.sv
`default_nettype none
// ============================================================================
// Module      : irq_src_sync
// Description : Per-source synchroniser chain followed by a rising-edge
//               detector (delay flop).
// Revision    : 1.0 - initial release
// ============================================================================
module irq_src_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nreset,
    input  logic src,
    output logic synced,
    output logic rise
);

    logic w_synced;
    logic r_dly;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign w_synced = src;
        end else begin : g_chain
            logic [SYNC_STAGES-1:0] r_sync;

            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= src;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_synced = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_dly <= 1'b0;
        end else begin
            r_dly <= w_synced;
        end
    end

    assign synced = w_synced;
    assign rise   = w_synced & ~r_dly;

endmodule : irq_src_sync
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : irq_controller
// Description : Prioritised interrupt controller with per-source mask,
//               pending and edge/level mode, plus ack/EOI handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_controller
    import irq_pkg::*;
#(
    parameter int                 NUM_SRC     = 8,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_SRC-1:0] MASK_RESET  = '0,
    parameter logic [NUM_SRC-1:0] MODE_RESET  = '1,
    localparam int                IDW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [NUM_SRC-1:0] src,
    input  logic [1:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    input  logic               reg_we,
    input  logic               reg_re,
    output logic [31:0]        reg_rdata,
    output logic               irq,
    output logic [IDW-1:0]     irq_id,
    input  logic               irq_ack,
    input  logic               irq_eoi
);

    logic [NUM_SRC-1:0] w_synced, w_rise, w_clr, w_pending_nxt, w_eligible;
    logic [NUM_SRC-1:0] r_pending, r_mask, r_mode;
    logic [1:0]         r_state, w_state_nxt;
    logic [IDW-1:0]     r_id, w_winner;
    logic [31:0]        r_rdata, w_rd_mux;
    logic               w_any, w_wr_pend;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            irq_src_sync #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync (
                .clk    (clk),
                .nreset (nreset),
                .src    (src[gi]),
                .synced (w_synced[gi]),
                .rise   (w_rise[gi])
            );
        end

        if (NUM_SRC < 32) begin : g_wdata_upper
            logic w_unused;
            assign w_unused = ^reg_wdata[31:NUM_SRC];
        end
    endgenerate

    assign w_wr_pend = reg_we && (reg_addr == REG_PENDING);

    // W1C and ack clears; a same-cycle rising edge still sets the bit.
    always_comb begin
        w_clr = '0;
        if (w_wr_pend) begin
            w_clr = reg_wdata[NUM_SRC-1:0];
        end
        if ((r_state == REQ) && irq_ack) begin
            w_clr[r_id] = 1'b1;
        end
    end

    assign w_pending_nxt = (r_mode & (w_rise | (r_pending & ~w_clr)))
                         | (~r_mode & w_synced);
    assign w_eligible    = r_pending & r_mask;
    assign w_any         = |w_eligible;

    always_comb begin
        w_winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = IDW'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = REQ;
            REQ: begin
                if (irq_ack) begin
                    w_state_nxt = ACTIVE;
                end else if (!w_eligible[r_id]) begin
                    w_state_nxt = IDLE;
                end
            end
            ACTIVE:  if (irq_eoi) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Id field is only meaningful while a handler is running.
    always_comb begin
        w_rd_mux = '0;
        case (reg_addr)
            REG_MASK:    w_rd_mux[NUM_SRC-1:0] = r_mask;
            REG_PENDING: w_rd_mux[NUM_SRC-1:0] = r_pending;
            REG_MODE:    w_rd_mux[NUM_SRC-1:0] = r_mode;
            REG_ACTIVE: begin
                if (r_state == ACTIVE) begin
                    w_rd_mux[ACTIVE_FLAG_BIT] = 1'b1;
                    w_rd_mux[IDW-1:0]         = r_id;
                end
            end
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= IDLE;
            r_id      <= '0;
            r_pending <= '0;
            r_mask    <= MASK_RESET;
            r_mode    <= MODE_RESET;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            if ((r_state == IDLE) && w_any) begin
                r_id <= w_winner;
            end
            if (reg_we && (reg_addr == REG_MASK)) begin
                r_mask <= reg_wdata[NUM_SRC-1:0];
            end
            if (reg_we && (reg_addr == REG_MODE)) begin
                r_mode <= reg_wdata[NUM_SRC-1:0];
            end
            if (reg_re) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign irq       = (r_state == REQ);
    assign irq_id    = r_id;
    assign reg_rdata = r_rdata;

endmodule : irq_controller
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_controller
// Description : Directed self-checking bench for irq_controller using an
//               expected-value queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

    localparam int NUM_SRC = 8;
    localparam int IDW     = 3;

    logic               clk = 1'b0;
    logic               nreset;
    logic [NUM_SRC-1:0] src;
    logic [1:0]         reg_addr;
    logic [31:0]        reg_wdata;
    logic               reg_we, reg_re;
    logic [31:0]        reg_rdata;
    logic               irq;
    logic [IDW-1:0]     irq_id;
    logic               irq_ack, irq_eoi;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       checks = 0;
    int       errors = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    irq_controller #(
        .NUM_SRC     (NUM_SRC),
        .SYNC_STAGES (2),
        .MASK_RESET  (8'h00),
        .MODE_RESET  (8'hFF)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .src       (src),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .irq       (irq),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack),
        .irq_eoi   (irq_eoi)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_item_t it;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow observed=%h expected=none", obs);
            return;
        end
        it = sb_q.pop_front();
        assert (obs === it.exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
        end
    endtask

    task automatic reg_write(input logic [1:0] addr, input logic [31:0] data);
        reg_addr  = addr;
        reg_wdata = data;
        reg_we    = 1'b1;
        tick();
        reg_we    = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] addr, output logic [31:0] data);
        reg_addr = addr;
        reg_re   = 1'b1;
        tick();
        reg_re   = 1'b0;
        data     = reg_rdata;
    endtask

    task automatic pulse_src(input logic [NUM_SRC-1:0] bits);
        src = src | bits;
        tick();
        src = src & ~bits;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic eoi();
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
    endtask

    initial begin
        nreset = 1'b0; src = '0; reg_addr = '0; reg_wdata = '0;
        reg_we = 1'b0; reg_re = 1'b0; irq_ack = 1'b0; irq_eoi = 1'b0;

        // Reset state
        sb_push("rst_irq", 32'h0);
        sb_push("rst_id", 32'h0);
        sb_push("rst_rdata", 32'h0);
        tick(3);
        sb_check({31'b0, irq});
        sb_check(32'(irq_id));
        sb_check(reg_rdata);
        nreset = 1'b1;
        sb_push("rst_mask", 32'h00);
        reg_read(2'd0, rd); sb_check(rd);
        sb_push("rst_mode", 32'hFF);
        reg_read(2'd2, rd); sb_check(rd);

        // Masked source becomes pending but never requests
        pulse_src(8'h08);
        tick(3);
        sb_push("masked_pending", 32'h08);
        sb_push("masked_irq", 32'h0);
        reg_read(2'd1, rd); sb_check(rd);
        sb_check({31'b0, irq});
        sb_push("unmask_irq_early", 32'h0);
        sb_push("unmask_irq", 32'h1);
        sb_push("unmask_id", 32'h3);
        reg_write(2'd0, 32'h08);
        sb_check({31'b0, irq});
        tick();
        sb_check({31'b0, irq});
        sb_check(32'(irq_id));
        sb_push("ack_irq_low", 32'h0);
        sb_push("active_reg", 32'h8000_0003);
        ack();
        sb_check({31'b0, irq});
        reg_read(2'd3, rd); sb_check(rd);
        eoi();

        // Simultaneous edges: lowest index wins; the other re-issues after EOI
        reg_write(2'd0, 32'hFF);
        src = 8'h24;
        sb_push("lat_irq_not_yet", 32'h0);
        sb_push("lat_irq", 32'h1);
        sb_push("prio_id", 32'h2);
        tick(3);
        sb_check({31'b0, irq});
        tick();
        src = 8'h00;
        sb_check({31'b0, irq});
        sb_check(32'(irq_id));
        sb_push("no_nesting", 32'h0);
        sb_push("eoi_cycle_irq", 32'h0);
        sb_push("reissue_irq", 32'h1);
        sb_push("reissue_id", 32'h5);
        ack();
        tick(2);
        sb_check({31'b0, irq});
        eoi();
        sb_check({31'b0, irq});
        tick();
        sb_check({31'b0, irq});
        sb_check(32'(irq_id));
        ack();
        eoi();

        // New edge on source 1 coincides with its ack: pending survives
        sb_push("src1_id", 32'h1);
        sb_push("set_wins_pending", 32'h02);
        pulse_src(8'h02);
        tick(3);
        sb_check(32'(irq_id));
        src[1] = 1'b1;
        tick(2);
        ack();
        src[1] = 1'b0;
        reg_read(2'd1, rd); sb_check(rd);
        eoi();
        tick();
        ack();
        eoi();
        sb_push("pending_drained", 32'h00);
        reg_read(2'd1, rd); sb_check(rd);

        // Level mode on source 0
        reg_write(2'd2, 32'hFE);
        src[0] = 1'b1;
        sb_push("level_id", 32'h0);
        sb_push("level_irq", 32'h1);
        sb_push("level_reissue_irq", 32'h1);
        sb_push("level_reissue_id", 32'h0);
        tick(5);
        sb_check(32'(irq_id));
        sb_check({31'b0, irq});
        ack();
        eoi();
        tick();
        sb_check({31'b0, irq});
        sb_check(32'(irq_id));
        sb_push("level_drop_hold", 32'h1);
        sb_push("level_drop_irq", 32'h0);
        sb_push("level_drop_active", 32'h0);
        src[0] = 1'b0;
        tick(3);
        sb_check({31'b0, irq});
        tick();
        sb_check({31'b0, irq});
        reg_read(2'd3, rd); sb_check(rd);
        reg_write(2'd2, 32'hFF);

        // W1C of the requested source withdraws the request
        pulse_src(8'h10);
        tick(3);
        sb_push("w1c_id", 32'h4);
        sb_push("w1c_irq_hold", 32'h1);
        sb_push("w1c_irq_drop", 32'h0);
        sb_push("w1c_active", 32'h0);
        sb_check(32'(irq_id));
        reg_write(2'd1, 32'h10);
        sb_check({31'b0, irq});
        tick();
        sb_check({31'b0, irq});
        reg_read(2'd3, rd); sb_check(rd);

        // Asynchronous reset while a handler is active
        pulse_src(8'hC0);
        tick(3);
        ack();
        sb_push("pre_rst_pending", 32'h80);
        reg_read(2'd1, rd); sb_check(rd);
        sb_push("arst_irq", 32'h0);
        sb_push("arst_id", 32'h0);
        sb_push("arst_rdata", 32'h0);
        #2;
        nreset = 1'b0;
        src = 8'h04;
        #1;
        sb_check({31'b0, irq});
        sb_check(32'(irq_id));
        sb_check(reg_rdata);
        tick(2);
        nreset = 1'b1;
        sb_push("post_rst_mask", 32'h00);
        sb_push("post_rst_pending", 32'h00);
        sb_push("post_rst_active", 32'h00);
        sb_push("redetect_pending", 32'h04);
        reg_read(2'd0, rd); sb_check(rd);
        reg_read(2'd1, rd); sb_check(rd);
        reg_read(2'd3, rd); sb_check(rd);
        tick();
        reg_read(2'd1, rd); sb_check(rd);

        // Same-cycle write and read of MASK returns the old value
        sb_push("rw_same_cycle", 32'h00);
        sb_push("rw_after", 32'h0F);
        reg_addr  = 2'd0;
        reg_wdata = 32'hFFFF_FF0F;
        reg_we    = 1'b1;
        reg_re    = 1'b1;
        tick();
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        sb_check(reg_rdata);
        reg_read(2'd0, rd); sb_check(rd);

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_irq_controller
`default_nettype wire
